// File: rtl/window_shift_buffer_if.sv
// rtl/window_shift_buffer_if.sv - Row-in / window-out handshake bundle for window_shift_buffer
//
// Purpose:
//   Groups the input row stream and the output window stream of the row-window
//   shift buffer. The buffer uses the slave modport; the producer/consumer side
//   (or a testbench) uses the master modport.
//
// Signals:
//   in_valid    producer -> buffer   in_row is valid
//   in_ready    buffer -> producer   buffer accepts a row this cycle
//   in_row      producer -> buffer   ROW_PIX*PIX_W, pixel c at [c*PIX_W +: PIX_W]
//   out_valid   buffer -> consumer   out_window holds a fresh full window
//   out_ready   consumer -> buffer   consumer takes the window this cycle
//   out_window  buffer -> consumer   DEPTH*ROW_PIX*PIX_W window
interface window_shift_buffer_if #(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 8,
  parameter int DEPTH   = 15
);
  logic                           in_valid;
  logic                           in_ready;
  logic [ROW_PIX*PIX_W-1:0]       in_row;
  logic                           out_valid;
  logic                           out_ready;
  logic [DEPTH*ROW_PIX*PIX_W-1:0] out_window;

  modport master (
    output in_valid,
    output in_row,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_window
  );

  modport slave (
    input  in_valid,
    input  in_row,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_window
  );
endinterface

// File: rtl/window_shift_buffer.sv
// rtl/window_shift_buffer.sv - Row-window shift buffer with fill tracking, back-pressure and flush
//
// Purpose:
//   Holds the last DEPTH rows of ROW_PIX pixels and presents them as one window
//   to the interpolation filter bank. Each accepted row shifts the window by one
//   row (row 0 is the oldest). A window is offered once DEPTH rows have been
//   accepted since reset or flush, and then once per further accepted row.
//
// Ports:
//   clock       in   rising-edge clock
//   reset_L     in   asynchronous active-low reset
//   flush       in   synchronous clear of rows, fill count and out_valid
//   transpose   in   column-major view select (only with WINDOW_TRANSPOSE_EN)
//   bus         slave modport of window_shift_buffer_if (row in / window out)
//   fill_cnt    out  rows held, saturates at DEPTH
//
// Configuration:
//   WINDOW_TRANSPOSE_EN  when defined, adds the transpose input; transpose=1
//                        presents pixel (r,c) at [(c*DEPTH + r)*PIX_W +: PIX_W].
//                        When undefined, the window is row-major only:
//                        pixel (r,c) at [(r*ROW_PIX + c)*PIX_W +: PIX_W].
module window_shift_buffer #(
  parameter  int PIX_W   = 8,
  parameter  int ROW_PIX = 8,
  parameter  int DEPTH   = 15,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset_L,
  input  logic                    flush,
`ifdef WINDOW_TRANSPOSE_EN
  input  logic                    transpose,
`endif
  window_shift_buffer_if.slave    bus,
  output logic [CNT_W-1:0]        fill_cnt
);

  localparam int ROW_W = ROW_PIX * PIX_W;
  localparam int WIN_W = DEPTH * ROW_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  // Row r lives at [r*ROW_W +: ROW_W]; this is already the row-major window.
  logic [WIN_W-1:0] window_q;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             push;
  logic             pop;

  // in_ready depends only on flush, the registered out_valid and out_ready,
  // never on in_valid.
  assign bus.in_ready  = ~flush & (~out_valid_q | bus.out_ready);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = out_valid_q & bus.out_ready;
  assign bus.out_valid = out_valid_q;

  // Shift: the new row enters at the top (row DEPTH-1), everything moves one
  // row toward row 0 and the oldest row falls off the bottom.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      window_q <= '0;
    end else if (flush) begin
      window_q <= '0;
    end else if (push) begin
      window_q <= {bus.in_row, window_q[WIN_W-1:ROW_W]};
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      fill_cnt <= '0;
    end else if (flush) begin
      fill_cnt <= '0;
    end else if (push && (fill_cnt < CNT_FULL)) begin
      fill_cnt <= fill_cnt + CNT_W'(1);
    end
  end

  // A push that brings the count to DEPTH (or arrives when already full)
  // produces a new window; this outranks a simultaneous pop so pop+push keeps
  // out_valid high without a bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (push && (fill_cnt >= CNT_LAST)) begin
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

`ifdef WINDOW_TRANSPOSE_EN
  logic [WIN_W-1:0] window_t;

  always_comb begin
    window_t = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < ROW_PIX; c++) begin
        window_t[(c*DEPTH + r)*PIX_W +: PIX_W] = window_q[(r*ROW_PIX + c)*PIX_W +: PIX_W];
      end
    end
  end

  // Pure view select: the registered state is identical in both layouts.
  assign bus.out_window = transpose ? window_t : window_q;
`else
  assign bus.out_window = window_q;
`endif

endmodule

// File: tb/tb_window_shift_buffer.sv
// tb/tb_window_shift_buffer.sv - Self-checking bench for window_shift_buffer
module tb_window_shift_buffer;

  localparam int PIX_W   = 8;
  localparam int ROW_PIX = 8;
  localparam int DEPTH   = 15;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ROW_W   = ROW_PIX * PIX_W;
  localparam int WIN_W   = DEPTH * ROW_W;

  logic             clock = 1'b0;
  logic             reset_L;
  logic             flush;
  logic             transpose;
  logic [CNT_W-1:0] fill_cnt;

  int checks = 0;
  int errors = 0;

  window_shift_buffer_if #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .DEPTH(DEPTH)) bus ();

  window_shift_buffer #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset_L  (reset_L),
    .flush    (flush),
`ifdef WINDOW_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .bus      (bus),
    .fill_cnt (fill_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: history of the last DEPTH rows (index 0 oldest, zeros
  // where nothing has been accepted yet), a count of accepted rows and a flag
  // telling whether an untaken full window is on offer.
  logic [ROW_W-1:0] m_rows[$];
  int               m_count;
  bit               m_valid;

  function automatic void model_clear();
    m_rows.delete();
    for (int i = 0; i < DEPTH; i++) m_rows.push_back('0);
    m_count = 0;
    m_valid = 1'b0;
  endfunction

  function automatic logic [WIN_W-1:0] model_window(input bit tr);
    logic [WIN_W-1:0] w;
    logic [ROW_W-1:0] row;
    w = '0;
    for (int r = 0; r < DEPTH; r++) begin
      row = m_rows[r];
      for (int c = 0; c < ROW_PIX; c++) begin
        if (tr) w[(c*DEPTH + r)*PIX_W +: PIX_W] = row[c*PIX_W +: PIX_W];
        else    w[(r*ROW_PIX + c)*PIX_W +: PIX_W] = row[c*PIX_W +: PIX_W];
      end
    end
    return w;
  endfunction

  function automatic logic [ROW_W-1:0] uniform_row(input int v);
    logic [ROW_W-1:0] row;
    for (int c = 0; c < ROW_PIX; c++) row[c*PIX_W +: PIX_W] = PIX_W'(v);
    return row;
  endfunction

  function automatic logic [ROW_W-1:0] random_row();
    logic [ROW_W-1:0] row;
    for (int c = 0; c < ROW_PIX; c++) row[c*PIX_W +: PIX_W] = PIX_W'($urandom_range(255));
    return row;
  endfunction

  // Row-major window whose pixel (r,c) equals base + r.
  function automatic logic [WIN_W-1:0] ramp_window(input int base);
    logic [WIN_W-1:0] w;
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < ROW_PIX; c++)
        w[(r*ROW_PIX + c)*PIX_W +: PIX_W] = PIX_W'(base + r);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".out_valid"}, WIN_W'(bus.out_valid), WIN_W'(m_valid));
    chk({tag, ".fill_cnt"}, WIN_W'(fill_cnt), WIN_W'((m_count < DEPTH) ? m_count : DEPTH));
    chk({tag, ".out_window"}, bus.out_window, model_window(transpose));
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model and DUT, check state.
  task automatic step(input string tag, input bit v, input bit ordy, input bit fl,
                      input logic [ROW_W-1:0] row);
    bit exp_rdy, push, pop;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    bus.in_row    = row;
    flush         = fl;
    #1;
    exp_rdy = !fl && (!m_valid || ordy);
    chk({tag, ".in_ready"}, WIN_W'(bus.in_ready), WIN_W'(exp_rdy));
    push = v && exp_rdy;
    pop  = m_valid && ordy;
    @(posedge clock);
    if (fl) begin
      model_clear();
    end else begin
      if (push) begin
        m_rows.push_back(row);
        void'(m_rows.pop_front());
        m_count++;
      end
      if (push && m_count >= DEPTH) m_valid = 1'b1;
      else if (pop)                 m_valid = 1'b0;
    end
    #1;
    chk_state(tag);
  endtask

  initial begin
    logic [WIN_W-1:0] held;
    reset_L       = 1'b0;
    flush         = 1'b0;
    transpose     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_row    = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    chk_state("reset");
    reset_L = 1'b1;

    // Asynchronous reset in the middle of a fill.
    for (int r = 0; r < 9; r++) step("prefill", 1'b1, 1'b1, 1'b0, random_row());
    chk("prefill.cnt9", WIN_W'(fill_cnt), WIN_W'(9));
    #2;
    reset_L = 1'b0;
    #1;
    chk("async_rst.fill_cnt", WIN_W'(fill_cnt), '0);
    chk("async_rst.out_valid", WIN_W'(bus.out_valid), '0);
    chk("async_rst.out_window", bus.out_window, '0);
    @(posedge clock);
    #1;
    reset_L = 1'b1;
    model_clear();

    // Fill with pixel = row index; window complete after row 14.
    for (int r = 0; r < DEPTH; r++) begin
      step("fill", 1'b1, 1'b1, 1'b0, uniform_row(r));
      if (r < DEPTH - 1) chk("fill.not_valid", WIN_W'(bus.out_valid), '0);
    end
    chk("fill.valid", WIN_W'(bus.out_valid), WIN_W'(1));
    chk("fill.cnt", WIN_W'(fill_cnt), WIN_W'(DEPTH));
    chk("fill.window", bus.out_window, ramp_window(0));

    // Slide: five back-to-back windows with no bubbles.
    for (int r = 15; r < 20; r++) begin
      step("slide", 1'b1, 1'b1, 1'b0, uniform_row(r));
      chk("slide.valid", WIN_W'(bus.out_valid), WIN_W'(1));
    end
    chk("slide.last_window", bus.out_window, ramp_window(5));

    // Stall: consumer not ready, producer offering rows.
    held = ramp_window(5);
    for (int i = 0; i < 4; i++) begin
      step("stall", 1'b1, 1'b0, 1'b0, uniform_row(100 + i));
      chk("stall.frozen", bus.out_window, held);
    end
    step("stall_release", 1'b1, 1'b1, 1'b0, uniform_row(20));
    chk("stall_release.window", bus.out_window, ramp_window(6));

    // Flush with a simultaneous row offer at full fill.
    step("flush", 1'b1, 1'b1, 1'b1, uniform_row(77));
    chk("flush.cnt", WIN_W'(fill_cnt), '0);
    chk("flush.valid", WIN_W'(bus.out_valid), '0);
    for (int r = 0; r < DEPTH; r++) begin
      step("refill", 1'b1, 1'b0, 1'b0, random_row());
      chk("refill.valid", WIN_W'(bus.out_valid), WIN_W'(r == DEPTH - 1));
    end
    step("drain", 1'b0, 1'b1, 1'b0, '0);

`ifdef WINDOW_TRANSPOSE_EN
    // Transpose view: pixel (r,c) = 16*r + c.
    step("tr_flush", 1'b0, 1'b1, 1'b1, '0);
    for (int r = 0; r < DEPTH; r++) begin
      logic [ROW_W-1:0] row;
      for (int c = 0; c < ROW_PIX; c++) row[c*PIX_W +: PIX_W] = PIX_W'(16*r + c);
      step("tr_fill", 1'b1, 1'b0, 1'b0, row);
    end
    transpose = 1'b1;
    #1;
    for (int r = 0; r < DEPTH; r += 7)
      for (int c = 0; c < ROW_PIX; c += 3)
        chk("tr.pixel", WIN_W'(bus.out_window[(c*DEPTH + r)*PIX_W +: PIX_W]), WIN_W'(16*r + c));
    chk_state("tr_view");
    transpose = 1'b0;
    #1;
    chk_state("tr_toggle_back");
    step("tr_drain", 1'b0, 1'b1, 1'b0, '0);
`endif

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
`ifdef WINDOW_TRANSPOSE_EN
      transpose = 1'($urandom_range(1));
`endif
      step("random", 1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
           ($urandom_range(31) == 0), random_row());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
